// File: rtl/mutex_req_ctrl_4_pkg.sv
// Shared definitions for the 4-way mutex requester controller.
// Channel state encoding, channel count and a grant popcount helper.
package mutex_req_ctrl_4_pkg;

    localparam int NCH = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_OWN  = 2'd2;
    localparam logic [1:0] ST_REL  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        REQ  = ST_REQ,
        OWN  = ST_OWN,
        REL  = ST_REL
    } chan_state_t;

    function automatic logic [2:0] popcount4(input logic [NCH-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int k = 0; k < NCH; k++) begin
            n = n + {2'b00, v[k]};
        end
        return n;
    endfunction

endpackage

// File: rtl/mutex_req_ctrl_4_if.sv
// Client/arbiter-facing bundle of the mutex requester controller.
// master drives starts, lengths and grants; slave is the controller.
interface mutex_req_ctrl_4_if #(
    parameter int LEN_W = 8
);
    import mutex_req_ctrl_4_pkg::*;

    logic [NCH-1:0]       start;
    logic [NCH*LEN_W-1:0] len;
    logic [NCH-1:0]       req;
    logic [NCH-1:0]       gnt;
    logic [NCH-1:0]       own;
    logic [NCH-1:0]       busy;
    logic [NCH-1:0]       done;
    logic [NCH-1:0]       timeout;
    logic                 err_multi;
    logic                 err_spurious;

    modport master (
        output start, len, gnt,
        input  req, own, busy, done, timeout,
        input  err_multi, err_spurious
    );

    modport slave (
        input  start, len, gnt,
        output req, own, busy, done, timeout,
        output err_multi, err_spurious
    );

endinterface

// File: rtl/mutex_req_ctrl_4_chan.sv
// One requester channel: grant synchronizer, FSM, hold and wait counters.
// All outputs are registered alongside the state.
module mutex_req_chan
    import mutex_req_ctrl_4_pkg::*;
#(
    parameter int LEN_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             gnt,
    output logic             req,
    output logic             own,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             gnt_s
);

    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WW-1:0]    W_ONE = 1;
    localparam logic [WW-1:0]    W_MAX = '1;
    localparam logic [WW-1:0]    W_LIM = TIMEOUT[WW-1:0];
    localparam logic [LEN_W-1:0] L_ONE = 1;

    chan_state_t            state;
    logic [LEN_W-1:0]       cnt;
    logic [WW-1:0]          wcnt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   via_to;

    assign gnt_s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            wcnt    <= '0;
            sync    <= '0;
            via_to  <= 1'b0;
            req     <= 1'b0;
            own     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            sync[0] <= gnt;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync[k] <= sync[k-1];
            end
            done    <= 1'b0;
            timeout <= 1'b0;
            unique case (state)
                // the done cycle still counts as leaving, so a start there is dropped
                IDLE: begin
                    if (start && !done) begin
                        state  <= REQ;
                        req    <= 1'b1;
                        busy   <= 1'b1;
                        via_to <= 1'b0;
                        wcnt   <= '0;
                        cnt    <= (len == '0) ? L_ONE : len;
                    end
                end
                REQ: begin
                    if (wcnt != W_MAX) begin
                        wcnt <= wcnt + W_ONE;
                    end
                    if (gnt_s) begin
                        state <= OWN;
                        own   <= 1'b1;
                    end else if (TIMEOUT != 0 && wcnt + W_ONE == W_LIM) begin
                        state   <= REL;
                        req     <= 1'b0;
                        timeout <= 1'b1;
                        via_to  <= 1'b1;
                    end
                end
                OWN: begin
                    if (cnt == L_ONE) begin
                        state <= REL;
                        req   <= 1'b0;
                        own   <= 1'b0;
                    end else begin
                        cnt <= cnt - L_ONE;
                    end
                end
                REL: begin
                    if (!gnt_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= !via_to;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mutex_req_ctrl_4.sv
// Four requester channels plus grant-bus exclusivity checkers.
// err_spurious needs two consecutive idle-grant cycles on one channel.
module mutex_req_ctrl_4
    import mutex_req_ctrl_4_pkg::*;
#(
    parameter int LEN_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input logic              clk,
    input logic              rst_n,
    mutex_req_ctrl_4_if.slave bus
);

    logic [NCH-1:0] req;
    logic [NCH-1:0] own;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] done;
    logic [NCH-1:0] timeout;
    logic [NCH-1:0] gnt_s;
    logic [NCH-1:0] sp_hit;
    logic [NCH-1:0] sp_run;
    logic           err_multi;
    logic           err_spurious;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        mutex_req_chan #(
            .LEN_W       (LEN_W),
            .SYNC_STAGES (SYNC_STAGES),
            .TIMEOUT     (TIMEOUT)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (bus.start[i]),
            .len     (bus.len[i*LEN_W +: LEN_W]),
            .gnt     (bus.gnt[i]),
            .req     (req[i]),
            .own     (own[i]),
            .busy    (busy[i]),
            .done    (done[i]),
            .timeout (timeout[i]),
            .gnt_s   (gnt_s[i])
        );
    end

    assign sp_hit = gnt_s & ~busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_multi    <= 1'b0;
            err_spurious <= 1'b0;
            sp_run       <= '0;
        end else begin
            sp_run <= sp_hit;
            if (popcount4(gnt_s) > 3'd1) begin
                err_multi <= 1'b1;
            end
            if (|(sp_hit & sp_run)) begin
                err_spurious <= 1'b1;
            end
        end
    end

    assign bus.req          = req;
    assign bus.own          = own;
    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.timeout      = timeout;
    assign bus.err_multi    = err_multi;
    assign bus.err_spurious = err_spurious;

endmodule

// File: tb/tb_mutex_req_ctrl_4.sv
// Bench for mutex_req_ctrl_4: vector table, corner sequences,
// and randomized traffic against a cycle-level behavioural model.
module tb_mutex_req_ctrl_4;

    localparam int LW = 8;
    localparam int SS = 2;
    localparam int TO = 10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mutex_req_ctrl_4_if #(.LEN_W(LW)) bus ();

    mutex_req_ctrl_4 #(
        .LEN_W       (LW),
        .SYNC_STAGES (SS),
        .TIMEOUT     (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int nvec = 0;
    int nmis = 0;
    int arb_mode = 0;

    // model: phase 0 idle, 1 waiting, 2 holding, 3 releasing
    int ph[4];
    int left[4];
    int waited[4];
    int run[4];
    bit ab[4];
    logic [3:0] e_req, e_own, e_busy, e_done, e_to;
    bit e_multi, e_spur;
    logic [3:0] gh[$];

    typedef struct {
        bit         r;
        logic [3:0] st;
        logic [7:0] l0;
        logic [3:0] g;
        logic [21:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, logic [3:0] st, logic [7:0] l0,
                                logic [3:0] g, logic [3:0] rq,
                                logic [3:0] ow, logic [3:0] bz,
                                logic [3:0] dn, logic [3:0] t);
        vec_t v;
        v.r = r; v.st = st; v.l0 = l0; v.g = g;
        v.exp = {rq, ow, bz, dn, t, 1'b0, 1'b0};
        return v;
    endfunction

    function automatic logic [31:0] dut_out();
        return {10'b0, bus.req, bus.own, bus.busy, bus.done,
                bus.timeout, bus.err_multi, bus.err_spurious};
    endfunction

    function automatic logic [31:0] mod_out();
        return {10'b0, e_req, e_own, e_busy, e_done, e_to,
                e_multi, e_spur};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [3:0] gs;
        logic [3:0] pd;
        int l;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                ph[i] = 0; left[i] = 0; waited[i] = 0;
                run[i] = 0; ab[i] = 0;
            end
            e_req = 0; e_own = 0; e_busy = 0; e_done = 0; e_to = 0;
            e_multi = 0; e_spur = 0;
            gh.delete();
            return;
        end
        gs = (gh.size() >= SS) ? gh[gh.size() - SS] : 4'b0;
        pd = e_done;
        if ($countones(gs) > 1) e_multi = 1;
        for (int i = 0; i < 4; i++) begin
            if (gs[i] && ph[i] == 0) run[i]++;
            else run[i] = 0;
            if (run[i] >= 2) e_spur = 1;
        end
        e_done = 0;
        e_to = 0;
        for (int i = 0; i < 4; i++) begin
            if (ph[i] == 0) begin
                if (bus.start[i] && !pd[i]) begin
                    l = int'(bus.len[i*LW +: LW]);
                    ph[i] = 1;
                    left[i] = (l == 0) ? 1 : l;
                    waited[i] = 0;
                end
            end else if (ph[i] == 1) begin
                waited[i]++;
                if (gs[i]) ph[i] = 2;
                else if (TO != 0 && waited[i] >= TO) begin
                    ph[i] = 3; ab[i] = 1; e_to[i] = 1;
                end
            end else if (ph[i] == 2) begin
                if (left[i] == 1) begin
                    ph[i] = 3; ab[i] = 0;
                end else left[i]--;
            end else begin
                if (!gs[i]) begin
                    ph[i] = 0; e_done[i] = !ab[i];
                end
            end
            e_req[i]  = (ph[i] == 1) || (ph[i] == 2);
            e_own[i]  = (ph[i] == 2);
            e_busy[i] = (ph[i] != 0);
        end
        gh.push_back(bus.gnt);
        if (gh.size() > 8) void'(gh.pop_front());
    endtask

    function automatic logic [3:0] arb_next(logic [3:0] g, logic [3:0] r,
                                            int mode);
        logic [3:0] o;
        int s;
        int k;
        o = '0;
        if (g != 0) return g & r;
        if (r == 0) return o;
        if (mode == 2 && $urandom_range(3) == 0) return o;
        s = (mode == 1) ? 0 : int'($urandom_range(3));
        for (int j = 0; j < 4; j++) begin
            k = (s + j) % 4;
            if (r[k]) begin
                o[k] = 1'b1;
                return o;
            end
        end
        return o;
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        if (arb_mode != 0) bus.gnt = arb_next(bus.gnt, bus.req, arb_mode);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.start = '0;
        bus.gnt = '0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int rc, tc, dc, ov, d1, d3;
        bit hit;
        rst_n = 1'b0;
        bus.start = '0;
        bus.len = '0;
        bus.gnt = '0;

        tbl.push_back(mk(0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
        tbl.push_back(mk(1, 4'h1, 3, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0));
        tbl.push_back(mk(1, 4'h0, 3, 4'h1, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0));
        tbl.push_back(mk(1, 4'h0, 3, 4'h1, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0));
        tbl.push_back(mk(1, 4'h0, 3, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0));
        tbl.push_back(mk(1, 4'h0, 3, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0));
        tbl.push_back(mk(1, 4'h0, 3, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0));
        tbl.push_back(mk(1, 4'h0, 3, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0));
        tbl.push_back(mk(1, 4'h0, 3, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0));
        tbl.push_back(mk(1, 4'h0, 3, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0));
        tbl.push_back(mk(1, 4'h0, 3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0));
        tbl.push_back(mk(1, 4'h1, 3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
        tbl.push_back(mk(1, 4'h0, 3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
        tbl.push_back(mk(1, 4'h1, 0, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0));
        tbl.push_back(mk(1, 4'h0, 0, 4'h1, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0));
        tbl.push_back(mk(1, 4'h0, 0, 4'h1, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0));
        tbl.push_back(mk(1, 4'h0, 0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0));
        tbl.push_back(mk(1, 4'h0, 0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0));
        tbl.push_back(mk(1, 4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0));
        tbl.push_back(mk(1, 4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0));
        tbl.push_back(mk(1, 4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0));
        tbl.push_back(mk(1, 4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));

        for (int n = 0; n < tbl.size(); n++) begin
            rst_n = tbl[n].r;
            bus.start = tbl[n].st;
            bus.len = {24'b0, tbl[n].l0};
            bus.gnt = tbl[n].g;
            step();
            chk($sformatf("tbl%0d", n), dut_out(), {10'b0, tbl[n].exp});
        end

        // timeout with grant held low
        do_reset();
        bus.start = 4'b0100;
        bus.len = {8'd4, 24'b0};
        step();
        bus.start = '0;
        rc = int'(bus.req[2]); tc = 0; dc = 0;
        for (int n = 0; n < 24; n++) begin
            step();
            rc += int'(bus.req[2]);
            tc += int'(bus.timeout[2]);
            dc += int'(bus.done[2]);
        end
        chk("to_req_cycles", rc, TO);
        chk("to_pulses", tc, 1);
        chk("to_no_done", dc, 0);
        chk("to_idle", {bus.busy[2], bus.req[2]}, 0);

        // contention between channels 3 and 1
        do_reset();
        arb_mode = 1;
        bus.start = 4'b1010;
        bus.len = {8'd2, 8'd0, 8'd2, 8'd0};
        step();
        bus.start = '0;
        ov = 0; d1 = 0; d3 = 0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (bus.own[1] && bus.own[3]) ov++;
            d1 += int'(bus.done[1]);
            d3 += int'(bus.done[3]);
        end
        chk("ct_overlap", ov, 0);
        chk("ct_done1", d1, 1);
        chk("ct_done3", d3, 1);
        chk("ct_err_multi", bus.err_multi, 0);
        arb_mode = 0;

        // multi-grant injection, one cycle wide
        do_reset();
        bus.gnt = 4'b0011;
        step();
        bus.gnt = '0;
        step();
        chk("em_early", bus.err_multi, 0);
        step();
        chk("em_set", bus.err_multi, 1);
        for (int n = 0; n < 5; n++) step();
        chk("em_sticky", bus.err_multi, 1);
        chk("es_single_cycle", bus.err_spurious, 0);

        // spurious grant on idle channel 3
        bus.gnt = 4'b1000;
        for (int n = 0; n < 3; n++) step();
        bus.gnt = '0;
        for (int n = 0; n < 4; n++) step();
        chk("es_set", bus.err_spurious, 1);

        // reset while channel 1 owns
        arb_mode = 1;
        bus.start = 4'b0010;
        bus.len = {16'd0, 8'd5, 8'd0};
        step();
        bus.start = '0;
        hit = 0;
        for (int n = 0; n < 20 && !hit; n++) begin
            step();
            hit = bus.own[1];
        end
        chk("rst_own_reached", hit, 1);
        rst_n = 1'b0;
        step();
        chk("rst_mid_own", {bus.req[1], bus.own[1], bus.busy[1], bus.done,
                            bus.err_multi, bus.err_spurious}, 0);
        rst_n = 1'b1;
        arb_mode = 0;
        bus.gnt = '0;
        step();

        // randomized traffic against the model
        arb_mode = 2;
        do_reset();
        for (int c = 0; c < 1200; c++) begin
            rst_n = ($urandom_range(399) != 0);
            for (int i = 0; i < 4; i++) begin
                bus.start[i] = ($urandom_range(3) == 0);
                bus.len[i*LW +: LW] = 8'($urandom_range(5));
            end
            step();
            chk("rand", dut_out(), mod_out());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
